// File: rtl/dbg_step_ctrl_if.sv
// Button/switch inputs and CPU-control outputs of the debug step controller.
interface dbg_step_ctrl_if #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned NUM_BP = 2,
    parameter int unsigned STEP_W = 8
);
    localparam int unsigned IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

    logic                     step_btn;
    logic                     run_btn;
    logic                     burst_btn;
    logic                     clr_btn;
    logic [STEP_W-1:0]        burst_len;
    logic [3:0]               sel;
    logic [PC_W-1:0]          pc;
    logic [NUM_BP*PC_W-1:0]   bp_addr;
    logic [NUM_BP-1:0]        bp_en;

    logic                     cpu_ce;
    logic [CNT_W-1:0]         cycle_cnt;
    logic                     busy;
    logic                     bp_hit;
    logic [IDX_W-1:0]         bp_idx;
    logic                     refresh;

    modport master (
        output step_btn, run_btn, burst_btn, clr_btn, burst_len, sel, pc, bp_addr, bp_en,
        input  cpu_ce, cycle_cnt, busy, bp_hit, bp_idx, refresh
    );

    modport slave (
        input  step_btn, run_btn, burst_btn, clr_btn, burst_len, sel, pc, bp_addr, bp_en,
        output cpu_ce, cycle_cnt, busy, bp_hit, bp_idx, refresh
    );
endinterface

// File: rtl/dbg_step_ctrl.sv
// Debug clock-step/run controller: single step, N-step burst, free run with
// PC breakpoints, wrapping cycle counter and display refresh strobe.
module dbg_step_ctrl #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned PC_W     = 32,
    parameter int unsigned NUM_BP   = 2,
    parameter int unsigned STEP_W   = 8,
    parameter int unsigned PACE_DIV = 2
) (
    input  logic           CCLK,
    input  logic           RST_N,
    dbg_step_ctrl_if.slave dbg
);
    localparam int unsigned IDX_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;
    localparam int unsigned PACE_W = (PACE_DIV > 1) ? $clog2(PACE_DIV) : 1;
    localparam logic [PACE_W-1:0] PACE_TC = PACE_W'(PACE_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_STEP  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    logic [1:0]        state_q,   state_d;
    logic [PACE_W-1:0] pace_q,    pace_d;
    logic [STEP_W-1:0] rem_q,     rem_d;
    logic              first_q,   first_d;
    logic              stop_q,    stop_d;
    logic              cpu_ce_q,  cpu_ce_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              busy_q,    busy_d;
    logic              bp_hit_q,  bp_hit_d;
    logic [IDX_W-1:0]  bp_idx_q,  bp_idx_d;
    logic              refresh_q, refresh_d;
    logic [3:0]        sel_q,     sel_d;
    // Button bit order: {clr, burst, run, step}
    logic [3:0]        btn_q,     btn_d;
    logic [3:0]        dly_q,     dly_d;

    logic [3:0]        edge_c;
    logic              step_e_c, run_e_c, burst_e_c, clr_e_c;
    logic              bp_any_c;
    logic [IDX_W-1:0]  bp_sel_c;
    logic              was_busy_c;

    assign edge_c    = btn_q & ~dly_q;
    assign step_e_c  = edge_c[0];
    assign run_e_c   = edge_c[1];
    assign burst_e_c = edge_c[2];
    assign clr_e_c   = edge_c[3];

    // Lowest enabled slot matching pc wins (descending scan, last write wins)
    always_comb begin
        bp_any_c = 1'b0;
        bp_sel_c = '0;
        for (int i = int'(NUM_BP) - 1; i >= 0; i--) begin
            if (dbg.bp_en[i] && (dbg.bp_addr[i*PC_W +: PC_W] == dbg.pc)) begin
                bp_any_c = 1'b1;
                bp_sel_c = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pace_d    = pace_q;
        rem_d     = rem_q;
        first_d   = first_q;
        stop_d    = stop_q;
        cpu_ce_d  = 1'b0;
        cnt_d     = cnt_q;
        bp_hit_d  = bp_hit_q;
        bp_idx_d  = bp_idx_q;
        refresh_d = 1'b0;
        sel_d     = sel_q;
        btn_d     = {dbg.clr_btn, dbg.burst_btn, dbg.run_btn, dbg.step_btn};
        dly_d     = btn_q;
        was_busy_c = (state_q == S_BURST) || (state_q == S_RUN);

        if (step_e_c || burst_e_c || run_e_c) begin
            bp_hit_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (step_e_c) begin
                    state_d  = S_STEP;
                    cpu_ce_d = 1'b1;
                end else if (burst_e_c || run_e_c) begin
                    state_d = burst_e_c ? S_BURST : S_RUN;
                    rem_d   = dbg.burst_len;
                    pace_d  = '0;
                    first_d = 1'b1;
                    stop_d  = 1'b0;
                end
            end
            S_STEP: begin
                state_d   = S_IDLE;
                refresh_d = 1'b1;
            end
            S_BURST, S_RUN: begin
                if (run_e_c) begin
                    stop_d = 1'b1;
                end
                if ((state_q == S_BURST) && (rem_q == '0)) begin
                    state_d = S_IDLE;
                end else if (pace_q == PACE_TC) begin
                    // Decision point: pc reflects the previous enable by now
                    pace_d = '0;
                    if (stop_q || run_e_c) begin
                        state_d = S_IDLE;
                    end else if (bp_any_c && !first_q) begin
                        state_d  = S_IDLE;
                        bp_hit_d = 1'b1;
                        bp_idx_d = bp_sel_c;
                    end else begin
                        cpu_ce_d = 1'b1;
                        first_d  = 1'b0;
                        if (state_q == S_BURST) begin
                            rem_d = rem_q - STEP_W'(1);
                        end
                    end
                end else begin
                    pace_d = pace_q + PACE_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_BURST) || (state_d == S_RUN);

        if (was_busy_c && (state_d == S_IDLE)) begin
            refresh_d = 1'b1;
        end
        if (clr_e_c) begin
            refresh_d = 1'b1;
        end
        if (dbg.sel != sel_q) begin
            sel_d     = dbg.sel;
            refresh_d = 1'b1;
        end

        // Clear wins over a coinciding increment; the enable itself still goes out
        if (clr_e_c) begin
            cnt_d = '0;
        end else if (cpu_ce_d) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            pace_q    <= '0;
            rem_q     <= '0;
            first_q   <= 1'b0;
            stop_q    <= 1'b0;
            cpu_ce_q  <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            bp_hit_q  <= 1'b0;
            bp_idx_q  <= '0;
            refresh_q <= 1'b0;
            sel_q     <= '0;
            btn_q     <= '0;
            dly_q     <= '0;
        end else begin
            state_q   <= state_d;
            pace_q    <= pace_d;
            rem_q     <= rem_d;
            first_q   <= first_d;
            stop_q    <= stop_d;
            cpu_ce_q  <= cpu_ce_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            bp_hit_q  <= bp_hit_d;
            bp_idx_q  <= bp_idx_d;
            refresh_q <= refresh_d;
            sel_q     <= sel_d;
            btn_q     <= btn_d;
            dly_q     <= dly_d;
        end
    end

    assign dbg.cpu_ce    = cpu_ce_q;
    assign dbg.cycle_cnt = cnt_q;
    assign dbg.busy      = busy_q;
    assign dbg.bp_hit    = bp_hit_q;
    assign dbg.bp_idx    = bp_idx_q;
    assign dbg.refresh   = refresh_q;
endmodule

// File: tb/tb_dbg_step_ctrl.sv
// Directed bench for dbg_step_ctrl; expected cycle_cnt per cpu_ce is queued
// ahead of each stimulus and popped by a monitor when the pulse appears.
module tb_dbg_step_ctrl;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned PC_W     = 32;
    localparam int unsigned NUM_BP   = 2;
    localparam int unsigned STEP_W   = 8;
    localparam int unsigned PACE_DIV = 2;

    logic CCLK  = 1'b0;
    logic RST_N = 1'b0;
    logic pc_clr = 1'b1;

    always #5 CCLK = ~CCLK;

    dbg_step_ctrl_if #(.CNT_W(CNT_W), .PC_W(PC_W), .NUM_BP(NUM_BP), .STEP_W(STEP_W)) bus ();

    dbg_step_ctrl #(
        .CNT_W(CNT_W), .PC_W(PC_W), .NUM_BP(NUM_BP), .STEP_W(STEP_W), .PACE_DIV(PACE_DIV)
    ) dut (
        .CCLK (CCLK),
        .RST_N(RST_N),
        .dbg  (bus)
    );

    int total = 0;
    int bad   = 0;
    int ce_seen  = 0;
    int ref_seen = 0;
    int cyc = 0;
    logic [CNT_W-1:0] exp_q[$];
    int pulse_cyc[$];
    logic [CNT_W-1:0] exp_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge CCLK);
    endtask

    // CPU model: next-PC advances by 4 one cycle after each enable
    always @(posedge CCLK) begin
        cyc <= cyc + 1;
        if (pc_clr) bus.pc <= '0;
        else if (bus.cpu_ce) bus.pc <= bus.pc + 32'd4;
    end

    always @(negedge CCLK) begin
        if (bus.refresh) ref_seen++;
        if (bus.cpu_ce) begin
            ce_seen++;
            pulse_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("ce_expected", 64'(exp_q.size() != 0), 64'd1);
            else chk("ce_cnt", 64'(bus.cycle_cnt), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        int ce0;
        int r0;
        int got;
        bus.step_btn  = 1'b0;
        bus.run_btn   = 1'b0;
        bus.burst_btn = 1'b0;
        bus.clr_btn   = 1'b0;
        bus.burst_len = '0;
        bus.sel       = 4'd0;
        bus.bp_addr   = '0;
        bus.bp_en     = '0;
        exp_cnt       = '0;

        // Reset state
        wait_n(3);
        chk("rst_cpu_ce", 64'(bus.cpu_ce), 64'd0);
        chk("rst_cnt", 64'(bus.cycle_cnt), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_bp_hit", 64'(bus.bp_hit), 64'd0);
        chk("rst_bp_idx", 64'(bus.bp_idx), 64'd0);
        chk("rst_refresh", 64'(bus.refresh), 64'd0);
        RST_N = 1'b1;
        wait_n(3);

        // Single step, then hold the button
        ce0 = ce_seen; r0 = ref_seen;
        exp_cnt = exp_cnt + 8'd1; exp_q.push_back(exp_cnt);
        bus.step_btn = 1'b1;
        wait_n(6);
        chk("step_ce_count", 64'(ce_seen - ce0), 64'd1);
        chk("step_refresh", 64'(ref_seen - r0), 64'd1);
        chk("step_cnt", 64'(bus.cycle_cnt), 64'd1);
        wait_n(10);
        chk("step_hold_ce", 64'(ce_seen - ce0), 64'd1);
        bus.step_btn = 1'b0;
        wait_n(3);

        // Burst of 5
        ce0 = ce_seen; r0 = ref_seen; pulse_cyc.delete();
        for (int k = 0; k < 5; k++) begin
            exp_cnt = exp_cnt + 8'd1; exp_q.push_back(exp_cnt);
        end
        bus.burst_len = 8'd5;
        bus.burst_btn = 1'b1;
        wait_n(3);
        chk("burst_busy", 64'(bus.busy), 64'd1);
        wait_n(14);
        chk("burst_ce_count", 64'(ce_seen - ce0), 64'd5);
        chk("burst_busy_end", 64'(bus.busy), 64'd0);
        chk("burst_refresh", 64'(ref_seen - r0), 64'd1);
        chk("burst_cnt", 64'(bus.cycle_cnt), 64'd6);
        for (int k = 1; k < pulse_cyc.size(); k++)
            chk("burst_spacing", 64'(pulse_cyc[k] - pulse_cyc[k-1]), 64'(PACE_DIV));
        bus.burst_btn = 1'b0;
        wait_n(2);

        // Burst of 0
        ce0 = ce_seen; r0 = ref_seen;
        bus.burst_len = 8'd0;
        bus.burst_btn = 1'b1;
        wait_n(2);
        chk("burst0_busy", 64'(bus.busy), 64'd1);
        wait_n(3);
        chk("burst0_busy_end", 64'(bus.busy), 64'd0);
        chk("burst0_ce_count", 64'(ce_seen - ce0), 64'd0);
        chk("burst0_refresh", 64'(ref_seen - r0), 64'd1);
        bus.burst_btn = 1'b0;
        wait_n(2);

        // Breakpoint in RUN: slot0 matches but is disabled
        bus.bp_addr = {32'h0000_000C, 32'h0000_000C};
        bus.bp_en   = 2'b10;
        pc_clr      = 1'b0;
        ce0 = ce_seen;
        for (int k = 0; k < 3; k++) begin
            exp_cnt = exp_cnt + 8'd1; exp_q.push_back(exp_cnt);
        end
        bus.run_btn = 1'b1;
        wait_n(20);
        chk("bp_ce_count", 64'(ce_seen - ce0), 64'd3);
        chk("bp_hit", 64'(bus.bp_hit), 64'd1);
        chk("bp_idx", 64'(bus.bp_idx), 64'd1);
        chk("bp_busy", 64'(bus.busy), 64'd0);
        chk("bp_pc", 64'(bus.pc), 64'h0C);

        // Resume from the breakpoint address, then stop after one more enable
        bus.run_btn = 1'b0;
        wait_n(2);
        ce0 = ce_seen;
        for (int k = 0; k < 2; k++) begin
            exp_cnt = exp_cnt + 8'd1; exp_q.push_back(exp_cnt);
        end
        bus.run_btn = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            @(negedge CCLK);
            if (bus.cpu_ce) got = 1;
        end
        chk("resume_seen", 64'(got), 64'd1);
        chk("resume_pc", 64'(bus.pc), 64'h0C);
        chk("resume_bp_clr", 64'(bus.bp_hit), 64'd0);
        bus.run_btn = 1'b0;
        wait_n(1);
        bus.run_btn = 1'b1;
        wait_n(12);
        chk("stop_ce_count", 64'(ce_seen - ce0), 64'd2);
        chk("stop_busy", 64'(bus.busy), 64'd0);
        chk("stop_bp_hit", 64'(bus.bp_hit), 64'd0);
        bus.run_btn = 1'b0;
        wait_n(2);

        // Clear, then 256 steps wrap back to zero
        r0 = ref_seen;
        bus.clr_btn = 1'b1;
        wait_n(4);
        chk("clr_cnt", 64'(bus.cycle_cnt), 64'd0);
        chk("clr_refresh", 64'(ref_seen - r0), 64'd1);
        bus.clr_btn = 1'b0;
        wait_n(2);
        exp_cnt = '0;
        for (int k = 0; k < 256; k++) begin
            exp_cnt = exp_cnt + 8'd1; exp_q.push_back(exp_cnt);
            bus.step_btn = 1'b1;
            wait_n(2);
            bus.step_btn = 1'b0;
            wait_n(2);
        end
        wait_n(2);
        chk("wrap_cnt", 64'(bus.cycle_cnt), 64'd0);
        chk("wrap_queue", 64'(exp_q.size()), 64'd0);

        // Clear coinciding with a step enable
        ce0 = ce_seen;
        exp_cnt = '0; exp_q.push_back(exp_cnt);
        bus.clr_btn  = 1'b1;
        bus.step_btn = 1'b1;
        wait_n(4);
        chk("clr_ce_ce_count", 64'(ce_seen - ce0), 64'd1);
        chk("clr_ce_cnt", 64'(bus.cycle_cnt), 64'd0);
        bus.clr_btn  = 1'b0;
        bus.step_btn = 1'b0;
        wait_n(2);

        // Refresh on sel change alone
        bus.sel = 4'd3;
        wait_n(4);
        ce0 = ce_seen; r0 = ref_seen;
        bus.sel = 4'd7;
        wait_n(4);
        chk("sel_refresh", 64'(ref_seen - r0), 64'd1);
        chk("sel_ce_count", 64'(ce_seen - ce0), 64'd0);

        // Reset in the middle of RUN, during an enable pulse
        bus.bp_en = 2'b00;
        for (int k = 0; k < 2; k++) begin
            exp_cnt = exp_cnt + 8'd1; exp_q.push_back(exp_cnt);
        end
        bus.run_btn = 1'b1;
        got = 0;
        for (int k = 0; k < 30 && got < 2; k++) begin
            @(negedge CCLK);
            if (bus.cpu_ce) got++;
        end
        chk("midrun_pulses", 64'(got), 64'd2);
        #2 RST_N = 1'b0;
        #1;
        chk("midrun_rst_ce", 64'(bus.cpu_ce), 64'd0);
        chk("midrun_rst_busy", 64'(bus.busy), 64'd0);
        chk("midrun_rst_bp_hit", 64'(bus.bp_hit), 64'd0);
        chk("midrun_rst_cnt", 64'(bus.cycle_cnt), 64'd0);
        bus.run_btn = 1'b0;
        wait_n(3);
        RST_N = 1'b1;
        ce0 = ce_seen;
        wait_n(10);
        chk("post_rst_ce_count", 64'(ce_seen - ce0), 64'd0);
        chk("post_rst_busy", 64'(bus.busy), 64'd0);
        chk("final_queue", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
